// File: rtl/rv64_mem_pkg.sv
// rv64_mem_pkg
// Shared definitions for the RV64 data-memory path: access-size encodings,
// the size-to-byte-count mapping and the default memory depth.
package rv64_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int DEFAULT_DMEM_DEPTH = 1024;

    // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rv64_load_ext.sv
// rv64_load_ext
// Pure combinational load extender. Takes a 64-bit little-endian raw value
// (the accessed bytes sit in the low bits) and sign- or zero-extends the
// low 8*N bits to 64 bits.
// Ports:
//   in_raw      - raw little-endian load value
//   in_size     - access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   in_unsigned - 1 = zero-extend, 0 = sign-extend
//   out_data    - extended result
module rv64_load_ext
    import rv64_mem_pkg::*;
(
    input  logic [63:0] in_raw,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic [63:0] out_data
);

    always_comb begin
        out_data = in_raw;
        case (in_size)
            SZ_B: out_data = in_unsigned ? {56'd0, in_raw[7:0]}
                                         : {{56{in_raw[7]}}, in_raw[7:0]};
            SZ_H: out_data = in_unsigned ? {48'd0, in_raw[15:0]}
                                         : {{48{in_raw[15]}}, in_raw[15:0]};
            SZ_W: out_data = in_unsigned ? {32'd0, in_raw[31:0]}
                                         : {{32{in_raw[31]}}, in_raw[31:0]};
            default: out_data = in_raw;
        endcase
    end

endmodule

// File: rtl/rv64_data_mem.sv
// rv64_data_mem
// Byte-addressable little-endian data memory for the single-cycle RV64 core.
// Stores commit on the rising clock edge; loads are combinational.
// Misaligned accesses are supported; out-of-range accesses (addr + N beyond
// the array, no address wrap) are ignored on store and read as 0 on load.
// Optional feature: define DMEM_ADDR_ERR_EN to add out_addr_err, which flags
// an out-of-range access (load or store) and is 0 during reset.
// Ports:
//   in_Clk       - clock
//   Rst_N        - asynchronous active-low reset, clears the whole array
//   in_addr      - byte address
//   in_data      - store data (low 8*N bits used)
//   in_wr_en     - store enable
//   in_size      - access size
//   in_unsigned  - load zero-extend (1) / sign-extend (0)
//   out_addr_err - out-of-range flag (only with DMEM_ADDR_ERR_EN)
//   out_data     - extended load data, 0 in reset or out of range
module rv64_data_mem
    import rv64_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_BYTES = DEFAULT_DMEM_DEPTH
)
(
    input  logic                  in_Clk,
    input  logic                  Rst_N,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr_en,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
`ifdef DMEM_ADDR_ERR_EN
    output logic                  out_addr_err,
`endif
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [DATA_WIDTH:0] DEPTH_END = (DATA_WIDTH+1)'(DEPTH_BYTES);

    logic [3:0]            nbytes;
    logic [DATA_WIDTH:0]   end_addr;
    logic                  in_range;
    logic [AW-1:0]         addr_idx;
    logic [7:0]            mem_q [DEPTH_BYTES];
    logic [7:0]            mem_d [DEPTH_BYTES];
    logic [63:0]           raw;
    logic [63:0]           ext;

    // One extra bit on the end address so a huge in_addr cannot wrap into range.
    assign nbytes   = size_bytes(in_size);
    assign end_addr = {1'b0, in_addr} + {{(DATA_WIDTH-3){1'b0}}, nbytes};
    assign in_range = (end_addr <= DEPTH_END);
    assign addr_idx = in_addr[AW-1:0];

    always_comb begin
        mem_d = mem_q;
        if (in_wr_en && in_range) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nbytes) begin
                    mem_d[addr_idx + AW'(k)] = in_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge in_Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Bytes beyond N may alias within the array; the extender discards them.
    always_comb begin
        raw = 64'd0;
        if (in_range) begin
            for (int k = 0; k < 8; k++) begin
                raw[8*k +: 8] = mem_q[addr_idx + AW'(k)];
            end
        end
    end

    rv64_load_ext u_load_ext (
        .in_raw      (raw),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .out_data    (ext)
    );

    assign out_data = Rst_N ? ext : '0;

`ifdef DMEM_ADDR_ERR_EN
    assign out_addr_err = Rst_N & ~in_range;
`endif

endmodule

// File: tb/tb_rv64_data_mem.sv
module tb_rv64_data_mem;

    logic        clk;
    logic        rst_n;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdata;
`ifdef DMEM_ADDR_ERR_EN
    logic        addr_err;
    logic        err_q [$];
`endif

    int n_vec;
    int n_err;

    logic [63:0] exp_q [$];
    logic [7:0]  model_mem [1024];

    rv64_data_mem #(.DATA_WIDTH(64), .DEPTH_BYTES(1024)) dut (
        .in_Clk      (clk),
        .Rst_N       (rst_n),
        .in_addr     (addr),
        .in_data     (wdata),
        .in_wr_en    (wr_en),
        .in_size     (size),
        .in_unsigned (uns),
`ifdef DMEM_ADDR_ERR_EN
        .out_addr_err(addr_err),
`endif
        .out_data    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, expv);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit model_in_range(input logic [63:0] a, input logic [1:0] sz);
        return a <= 64'(1024 - nb(sz));
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                               input logic u);
        logic [63:0] v;
        int n;
        n = nb(sz);
        v = '0;
        if (!model_in_range(a, sz)) return '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = model_mem[int'(a) + k];
        if (!u && n < 8) begin
            for (int b = 8*n; b < 64; b++) v[b] = v[8*n-1];
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'd0;
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        @(negedge clk);
        addr = a; wdata = d; size = sz; uns = 1'b0; wr_en = 1'b1;
        @(posedge clk);
        if (rst_n && model_in_range(a, sz)) begin
            for (int k = 0; k < nb(sz); k++) model_mem[int'(a) + k] = d[8*k +: 8];
        end
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] expv);
        @(negedge clk);
        addr = a; size = sz; uns = u; wr_en = 1'b0;
        exp_q.push_back(expv);
`ifdef DMEM_ADDR_ERR_EN
        err_q.push_back(!model_in_range(a, sz));
`endif
        #1;
        chk(tag, rdata, exp_q.pop_front());
`ifdef DMEM_ADDR_ERR_EN
        chk({tag, "_err"}, {63'd0, addr_err}, {63'd0, err_q.pop_front()});
`endif
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rd;
        logic [1:0]  rs;
        logic        ru;

        n_vec = 0;
        n_err = 0;
        model_clear();
        rst_n = 1'b0;
        addr = '0; wdata = '0; wr_en = 1'b0; size = 2'b11; uns = 1'b0;

        // 1. reset
        #1;
        chk("in_reset", rdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_load("rst_0",    64'h0,   2'b11, 1'b0, 64'd0);
        do_load("rst_8",    64'h8,   2'b11, 1'b0, 64'd0);
        do_load("rst_1016", 64'h3F8, 2'b11, 1'b0, 64'd0);

        // 2. double store/load
        do_store(64'h10, 64'h1122334455667788, 2'b11);
        do_load("d_load",  64'h10, 2'b11, 1'b0, 64'h1122334455667788);
        do_load("b_lo",    64'h10, 2'b00, 1'b1, 64'h88);
        do_load("b_hi",    64'h17, 2'b00, 1'b1, 64'h11);

        // 3. extension
        do_store(64'h20, 64'hF0, 2'b00);
        do_load("b_sext",  64'h20, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFF0);
        do_load("b_zext",  64'h20, 2'b00, 1'b1, 64'h00000000000000F0);
        do_store(64'h24, 64'h80000000, 2'b10);
        do_load("w_sext",  64'h24, 2'b10, 1'b0, 64'hFFFFFFFF80000000);
        do_load("w_zext",  64'h24, 2'b10, 1'b1, 64'h0000000080000000);
        do_store(64'h28, 64'h8001, 2'b01);
        do_load("h_sext",  64'h28, 2'b01, 1'b0, 64'hFFFFFFFFFFFF8001);

        // 4. partial and misaligned
        do_store(64'h30, 64'hFFFFFFFFFFFFFFFF, 2'b11);
        do_store(64'h33, 64'hABCD, 2'b01);
        do_load("part_d",  64'h30, 2'b11, 1'b0, 64'hFFFFFFABCDFFFFFF);
        do_load("mis_w",   64'h33, 2'b10, 1'b1, 64'h00000000FFFFABCD);

        // 5. range boundary
        do_store(64'h3F8, 64'hA5A5_0102_0304_5A5A, 2'b11);
        do_load("top_d",   64'h3F8, 2'b11, 1'b0, 64'hA5A5_0102_0304_5A5A);
        do_store(64'h3FC, 64'h1234_5678_9ABC_DEF0, 2'b11);
        do_load("oob_d",   64'h3FC, 2'b11, 1'b0, 64'd0);
        do_load("edge_w",  64'h3FC, 2'b10, 1'b1, 64'h00000000A5A50102);
        do_load("edge_b",  64'h3FF, 2'b00, 1'b1, 64'hA5);
        do_store(64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11);
        do_load("wrap_d",  64'hFFFF_FFFF_FFFF_FFF8, 2'b11, 1'b0, 64'd0);
        do_load("wrap_chk",64'h3F8, 2'b11, 1'b0, 64'hA5A5_0102_0304_5A5A);
        do_load("hi_addr", 64'h0000_0001_0000_0010, 2'b11, 1'b0, 64'd0);

        // 6a. write enable low
        @(negedge clk);
        addr = 64'h10; wdata = 64'hCAFE_CAFE_CAFE_CAFE; size = 2'b11; wr_en = 1'b0;
        @(posedge clk);
        do_load("wr_en_0", 64'h10, 2'b11, 1'b0, 64'h1122334455667788);

        // random traffic against the byte model
        for (int i = 0; i < 80; i++) begin
            rs = 2'($urandom_range(0, 3));
            ra = 64'($urandom_range(0, 1030));
            rd = {$urandom, $urandom};
            ru = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) do_store(ra, rd, rs);
            else do_load("rand", ra, rs, ru, model_load(ra, rs, ru));
        end

        // 6b. reset between edges, then a store held during reset
        do_store(64'h40, 64'h0BAD_F00D_0BAD_F00D, 2'b11);
        @(negedge clk);
        addr = 64'h40; size = 2'b11; uns = 1'b0; wr_en = 1'b0;
        #1;
        chk("pre_rst", rdata, 64'h0BAD_F00D_0BAD_F00D);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst", rdata, 64'd0);
        @(negedge clk);
        addr = 64'h50; wdata = 64'hDEAD_DEAD_DEAD_DEAD; size = 2'b11; wr_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_store", rdata, 64'd0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        do_load("post_40", 64'h40, 2'b11, 1'b0, 64'd0);
        do_load("post_50", 64'h50, 2'b11, 1'b0, 64'd0);
        do_load("post_10", 64'h10, 2'b11, 1'b0, 64'd0);
        do_load("post_3f8",64'h3F8, 2'b11, 1'b0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv64_data_mem.md
Name: rv64_data_mem

Overview:
- Byte-addressable, little-endian data memory serving the load/store path of the single-cycle RV64IF core.
- Stores are synchronous and take effect at the rising clock edge; loads are combinational, so the core sees load data in the same cycle.
- Supports byte/half/word/double access sizes with sign or zero extension on loads.
- Reset clears the whole array.

Parameters:
- DATA_WIDTH, 64, width of the address, write data and read data buses.
- DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least 8.

Ports:
- in_Clk  input  1  clock; stores commit on the rising edge.
- Rst_N  input  1  asynchronous active-low reset.
- in_addr  input  DATA_WIDTH  byte address of the access.
- in_data  input  DATA_WIDTH  store data; the low 8·2^in_size bits are used.
- in_wr_en  input  1  store enable.
- in_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- in_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- out_data  output  DATA_WIDTH  load data, extended to 64 bits.

Behaviour:
- Storage: DEPTH_BYTES × 8-bit registers.
- Reset: Rst_N low asynchronously clears every byte to 0 and forces out_data to 0 while Rst_N is low.
- Store is accepted only on a rising in_Clk edge with Rst_N=1, in_wr_en=1 and the access in range.
  - Bytes in_addr .. in_addr+N-1 receive in_data[8k+7:8k] for k = 0..N-1, where N = 1,2,4,8 from in_size.
  - Byte order is little-endian.
- Load is combinational, evaluated every cycle regardless of in_wr_en.
  - Assembles N bytes from in_addr little-endian.
  - Extends to 64 bits: sign-extend from bit 8N-1 when in_unsigned=0, zero-extend when 1.
  - For in_size=11, extension is a no-op.
- Alignment: misaligned accesses are fully supported; there is no trap.
- Range: an access is in range iff in_addr + N ≤ DEPTH_BYTES, compared on the full 64-bit address with no wrap.
  - Out-of-range store: ignored, memory unchanged.
  - Out-of-range load: out_data = 0.
  - An access straddling the top boundary is entirely out of range.
- Read during write, same address:
  - Before the edge, out_data shows the old contents.
  - After the edge, it shows the new contents (combinational read of the array).
- Reset asserted mid-cycle or at a clock edge: the clear wins and no store commits.
- Latency: store visible to loads one edge after it is presented; load latency 0 cycles.

Optional Feature:
- Macro DMEM_ADDR_ERR_EN.
- Defined: adds output out_addr_err (1 bit, combinational). It is 1 when the current access, load or store, is out of range. It is 0 during reset.
- Undefined: no such port; out-of-range behaviour is unchanged.

Decomposition:
- Package rv64_mem_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_D=2'b11;
  - a function mapping size to byte count;
  - DEFAULT_DMEM_DEPTH=1024.
- One sub-module, rv64_load_ext: pure combinational extender taking a 64-bit raw little-endian value, in_size and in_unsigned, and producing the 64-bit extended result. The core's load path may reuse it.

Test Plan:
1. Reset: Rst_N=0, then 1 → loads at addresses 0, 8 and 1016 (size D) read 0; out_data=0 while in reset.
2. Double store/load: store D 0x1122334455667788 at 0x10 → D load = 0x1122334455667788; B load at 0x10 = 0x88; B load at 0x17 = 0x11.
3. Extension: store B 0xF0 at 0x20.
   - B signed load → 0xFFFFFFFFFFFFFFF0; B unsigned load → 0x00000000000000F0.
   - Store W 0x80000000 at 0x24 → W signed load = 0xFFFFFFFF80000000.
4. Partial and misaligned store: store D all-ones at 0x30, then store H 0xABCD at 0x33 → D load at 0x30 = 0xFFFFFFABCDFFFFFF; misaligned W load at 0x33 unsigned = 0xFFFFABCD.
5. Range boundary (DEPTH_BYTES=1024):
   - Store D at 0x3F8 succeeds.
   - Store D at 0x3FC is ignored; a load there = 0, with out_addr_err=1 when DMEM_ADDR_ERR_EN is defined.
   - Address 0xFFFF_FFFF_FFFF_FFF8 is out of range.
6. Control:
   - Store with in_wr_en=0 leaves memory unchanged.
   - Asserting Rst_N=0 between edges after stores clears all data immediately, and a store presented while reset is low does not commit.
